// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the instruction sequencer: FSM states, instruction
// layout and opcode/ALU-select values.
package instr_sequencer_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned REG_AW   = 2;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned SEL_W    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  // Opcode values double as the ALU select encoding.
  typedef enum logic [SEL_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_DIV = 3'd6,
    OP_CMP = 3'd7
  } opcode_t;

  // Field positions: [15] ldi, [14:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
  typedef struct packed {
    logic              ldi;
    opcode_t           opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [DATA_W-1:0] imm;
  } instr_t;

endpackage

// File: rtl/regfile_4x8.sv
// Four 8-bit general-purpose registers: one write port, operand and debug reads.
module regfile_4x8
  import instr_sequencer_pkg::*;
#(
  parameter logic [DATA_W-1:0] REG_INIT = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] raddr_dbg,
  output logic [DATA_W-1:0] rdata_dbg
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= REG_INIT;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a   = regs_q[raddr_a];
  assign rdata_b   = regs_q[raddr_b];
  assign rdata_dbg = regs_q[raddr_dbg];

endmodule

// File: rtl/instr_sequencer.sv
// Four-state instruction sequencer: fetch, read operands, drive an external
// ALU, then write back the ALU result or an immediate.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_sel,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry,
  output logic        result_valid,
  output logic [7:0]  result_data,
  output logic        carry_flag,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  state_t            state_q, state_d;
  instr_t            instr_q;
  logic              carry_pend_q;
  logic [DATA_W-1:0] rd_data, rs_data;
  logic              accept;

  assign instr_ready = (state_q == IDLE);
  assign accept      = instr_valid && (state_q == IDLE);

  regfile_4x8 #(.REG_INIT(REG_INIT)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (state_q == WB),
    .waddr     (instr_q.rd),
    .wdata     (result_data),
    .raddr_a   (instr_q.rd),
    .rdata_a   (rd_data),
    .raddr_b   (instr_q.rs),
    .rdata_b   (rs_data),
    .raddr_dbg (dbg_addr),
    .rdata_dbg (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = DECODE;
      DECODE:  state_d = instr_q.ldi ? WB : EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are latched straight into the ALU drive registers so they are
  // stable for the whole EXEC settle cycle and through WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q      <= '0;
      alu_a        <= 8'h00;
      alu_b        <= 8'h00;
      alu_sel      <= 3'b000;
      result_valid <= 1'b0;
      result_data  <= 8'h00;
      carry_pend_q <= 1'b0;
      carry_flag   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (accept) instr_q <= instr_t'(instr);
      if (state_q == DECODE) begin
        if (instr_q.ldi) begin
          result_valid <= 1'b1;
          result_data  <= instr_q.imm;
        end else begin
          alu_a   <= rd_data;
          alu_b   <= rs_data;
          alu_sel <= instr_q.opcode;
        end
      end
      if (state_q == EXEC) begin
        result_valid <= 1'b1;
        result_data  <= alu_result;
        carry_pend_q <= alu_carry;
      end
      if (state_q == WB && !instr_q.ldi) carry_flag <= carry_pend_q;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a behavioural ALU and a writeback scoreboard.
module tb_instr_sequencer;

  localparam logic [7:0] INIT = 8'hA5;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        result_valid;
  logic [7:0]  result_data;
  logic        carry_flag;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_r [4];
  logic       m_c;
  logic [7:0] exp_q [$];

  instr_sequencer #(.REG_INIT(INIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .result_valid (result_valid),
    .result_data  (result_data),
    .carry_flag   (carry_flag),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {carry, result}.
  function automatic logic [8:0] alu_f(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    case (sel)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: begin
        p = 16'(a) * 16'(b);
        return {|p[15:8], p[7:0]};
      end
      3'd6: begin
        if (b == 8'h00) return 9'h100;
        return {1'b0, a / b};
      end
      default: return {8'h00, a == b};
    endcase
  endfunction

  always_comb {alu_carry, alu_result} = alu_f(alu_sel, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: every writeback must match the oldest outstanding entry.
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      check("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) check("wb_data", 32'(result_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic push_expected(input logic [15:0] w, output logic [7:0] ea, output logic [7:0] eb,
                               output logic [2:0] es);
    logic [1:0] rd, rs;
    logic [8:0] f;
    rd = w[11:10];
    rs = w[9:8];
    ea = m_r[rd];
    eb = m_r[rs];
    es = w[14:12];
    if (w[15]) begin
      exp_q.push_back(w[7:0]);
      m_r[rd] = w[7:0];
    end else begin
      f = alu_f(es, ea, eb);
      exp_q.push_back(f[7:0]);
      m_r[rd] = f[7:0];
      m_c     = f[8];
    end
  endtask

  task automatic issue(input logic [15:0] w);
    int n;
    int lat;
    logic [7:0] ea, eb;
    logic [2:0] es;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(instr_ready), 32'd1);
    instr       = w;
    instr_valid = 1'b1;
    push_expected(w, ea, eb, es);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'h0000;
    lat = 1;
    while (!result_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), w[15] ? 32'd2 : 32'd3);
    if (!w[15]) begin
      check("alu_sel", 32'(alu_sel), 32'(es));
      check("alu_a", 32'(alu_a), 32'(ea));
      check("alu_b", 32'(alu_b), 32'(eb));
    end
    @(negedge clk);
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [7:0] expv);
    dbg_addr = idx;
    #1;
    check(tag, 32'(dbg_data), 32'(expv));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] words [3];
    int acc_cyc [3];
    int idx;
    int cyc;
    int n;

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    dbg_addr    = 2'd0;
    for (int i = 0; i < 4; i++) m_r[i] = INIT;
    m_c = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_rdata", 32'(result_data), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    check("rst_carry", 32'(carry_flag), 32'd0);
    for (int i = 0; i < 4; i++) chk_reg("rst_reg", 2'(i), INIT);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(instr_ready), 32'd1);

    // ldi R1 = 05
    issue(16'h8505);
    chk_reg("ldi_r1", 2'd1, 8'h05);
    check("ldi_carry", 32'(carry_flag), 32'd0);
    check("ldi_alu_hold", 32'({alu_sel, alu_a, alu_b}), 32'd0);

    // add with carry out
    issue(16'h84F0);
    issue(16'h8820);
    issue(16'h0600);
    chk_reg("add_r1", 2'd1, 8'h10);
    check("add_carry", 32'(carry_flag), 32'd1);
    check("add_hold_a", 32'(alu_a), 32'hF0);

    // divide by zero, then ldi leaves carry alone
    issue(16'h8C07);
    issue(16'h8000);
    issue(16'h6C00);
    chk_reg("div_r3", 2'd3, 8'h00);
    check("div_carry", 32'(carry_flag), 32'd1);
    issue(16'h8533);
    check("ldi_keeps_carry", 32'(carry_flag), 32'd1);

    // cmp R0,R0 (rd == rs)
    issue(16'h7000);
    chk_reg("cmp_r0", 2'd0, 8'h01);
    check("cmp_carry", 32'(carry_flag), 32'd0);

    // Back-to-back words with instr_valid held high; non-accepted slots carry a poison ldi
    words[0] = 16'h4900;
    words[1] = 16'h3E00;
    words[2] = 16'h5500;
    idx = 0;
    cyc = 0;
    instr_valid = 1'b1;
    while (idx < 3 && cyc < 60) begin
      if (instr_ready) begin
        logic [7:0] ea, eb;
        logic [2:0] es;
        instr = words[idx];
        push_expected(words[idx], ea, eb, es);
        acc_cyc[idx] = cyc;
        idx++;
      end else begin
        instr = 16'h8CEE;
      end
      @(negedge clk);
      cyc++;
    end
    instr_valid = 1'b0;
    instr       = 16'h0000;
    check("stream_accepts", 32'(idx), 32'd3);
    check("stream_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    check("stream_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) chk_reg("stream_reg", 2'(i), m_r[i]);
    check("stream_carry", 32'(carry_flag), 32'(m_c));

    // Reset during EXEC of sub R2,R2 aborts without writeback
    issue(16'h8809);
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    instr       = 16'h1A00;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'h0000;
    @(negedge clk);
    check("exec_sel", 32'(alu_sel), 32'd1);
    check("exec_a", 32'(alu_a), 32'h09);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) m_r[i] = INIT;
    m_c = 1'b0;
    #1;
    check("abort_ready", 32'(instr_ready), 32'd1);
    check("abort_rv", 32'(result_valid), 32'd0);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    chk_reg("abort_r2", 2'd2, INIT);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_rel_ready", 32'(instr_ready), 32'd1);
    chk_reg("abort_rel_r2", 2'd2, INIT);
    check("abort_carry", 32'(carry_flag), 32'd0);

    // Recovery after abort
    issue(16'h0900);
    chk_reg("recover_r2", 2'd2, m_r[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
